// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: turns a 5-bit twisted-ring count into a phase index
// and one-hot phase, checks that successive samples follow the ring sequence,
// and counts completed revolutions once the sequence has been locked onto.
module johnson_phase_decoder #(
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       count_in,
    input  logic             sample_en,
    input  logic             clr_err,
    output logic [9:0]       phase_onehot,
    output logic [3:0]       phase_idx,
    output logic             valid,
    output logic             illegal_code,
    output logic             seq_error,
    output logic             err_sticky,
    output logic [REV_W-1:0] rev_count,
    output logic             rev_tick,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic             armed;
    logic             nxt_armed;
    logic [9:0]       nxt_onehot;
    logic [3:0]       nxt_idx;
    logic             nxt_illegal;
    logic             nxt_seq;
    logic             nxt_sticky;
    logic [REV_W-1:0] nxt_rev;
    logic             nxt_tick;

    logic             code_legal;
    logic [3:0]       code_idx;
    logic [3:0]       idx_inc;
    logic             is_hold;
    logic             is_advance;

    // Map the incoming count onto its ring position; anything else is illegal.
    always_comb begin
        code_legal = 1'b1;
        code_idx   = 4'd0;
        case (count_in)
            5'b00000: code_idx = 4'd0;
            5'b00001: code_idx = 4'd1;
            5'b00011: code_idx = 4'd2;
            5'b00111: code_idx = 4'd3;
            5'b01111: code_idx = 4'd4;
            5'b11111: code_idx = 4'd5;
            5'b11110: code_idx = 4'd6;
            5'b11100: code_idx = 4'd7;
            5'b11000: code_idx = 4'd8;
            5'b10000: code_idx = 4'd9;
            default:  code_legal = 1'b0;
        endcase
    end

    // The last accepted index is the reference for hold/advance decisions.
    assign idx_inc    = (phase_idx == 4'd9) ? 4'd0 : phase_idx + 4'd1;
    assign is_hold    = (code_idx == phase_idx);
    assign is_advance = (code_idx == idx_inc);

    // Next-state and next-output computation; pulses default low every cycle.
    always_comb begin
        nxt_state   = cur_state;
        nxt_armed   = armed;
        nxt_onehot  = phase_onehot;
        nxt_idx     = phase_idx;
        nxt_illegal = 1'b0;
        nxt_seq     = 1'b0;
        nxt_sticky  = err_sticky;
        nxt_rev     = rev_count;
        nxt_tick    = 1'b0;
        if (sample_en) begin
            if (code_legal) begin
                nxt_idx    = code_idx;
                nxt_onehot = 10'd1 << code_idx;
            end else begin
                nxt_onehot = 10'd0;
            end
            case (cur_state)
                SYNC: begin
                    if (!code_legal) begin
                        nxt_illegal = 1'b1;
                        nxt_armed   = 1'b0;
                    end else if (armed && is_advance) begin
                        nxt_state = TRACK;
                        nxt_armed = 1'b0;
                    end else begin
                        nxt_armed = 1'b1;
                    end
                end
                TRACK: begin
                    if (!code_legal) begin
                        nxt_illegal = 1'b1;
                        nxt_sticky  = 1'b1;
                        nxt_state   = FAULT;
                    end else if (!(is_hold || is_advance)) begin
                        nxt_seq    = 1'b1;
                        nxt_sticky = 1'b1;
                        nxt_state  = FAULT;
                    end else if (phase_idx == 4'd9 && code_idx == 4'd0) begin
                        nxt_rev  = rev_count + {{(REV_W-1){1'b0}}, 1'b1};
                        nxt_tick = 1'b1;
                    end
                end
                FAULT: begin
                    if (clr_err) begin
                        nxt_state  = SYNC;
                        nxt_sticky = 1'b0;
                        nxt_armed  = 1'b0;
                    end
                end
                default: begin
                    nxt_state = SYNC;
                    nxt_armed = 1'b0;
                end
            endcase
        end
    end

    // Register every output so they all reflect the previous enabled sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state    <= SYNC;
            armed        <= 1'b0;
            phase_onehot <= 10'd0;
            phase_idx    <= 4'd0;
            illegal_code <= 1'b0;
            seq_error    <= 1'b0;
            err_sticky   <= 1'b0;
            rev_count    <= '0;
            rev_tick     <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            armed        <= nxt_armed;
            phase_onehot <= nxt_onehot;
            phase_idx    <= nxt_idx;
            illegal_code <= nxt_illegal;
            seq_error    <= nxt_seq;
            err_sticky   <= nxt_sticky;
            rev_count    <= nxt_rev;
            rev_tick     <= nxt_tick;
        end
    end

    assign state = cur_state;
    assign valid = (cur_state == TRACK);

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 Parameter REV_W, default 8, SHALL set the width of the revolution counter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 count_in  input  5  SHALL be the Johnson count from the upstream 5-bit twisted ring counter.
REQ-005 sample_en  input  1  SHALL qualify count_in; when it is 0, no state changes except reset.
REQ-006 clr_err  input  1  SHALL clear the sticky error and leave FAULT; it is a single-cycle request.
REQ-007 phase_onehot  output  10  SHALL be the one-hot decoded phase, bit k meaning index k.
REQ-008 phase_idx  output  4  SHALL be the binary phase index 0..9.
REQ-009 valid  output  1  SHALL be high only while the FSM is in TRACK.
REQ-010 illegal_code  output  1  SHALL be a one-cycle pulse flagging a sampled non-Johnson code.
REQ-011 seq_error  output  1  SHALL be a one-cycle pulse flagging a legal code with an illegal succession while in TRACK.
REQ-012 err_sticky  output  1  SHALL be the latched error flag.
REQ-013 rev_count  output  REV_W  SHALL be the count of completed revolutions.
REQ-014 rev_tick  output  1  SHALL be a one-cycle pulse on each completed revolution.
REQ-015 state  output  2  SHALL encode the FSM state: SYNC=0, TRACK=1, FAULT=2.

Function
REQ-016 The legal code map SHALL be: 00000=0, 00001=1, 00011=2, 00111=3, 01111=4, 11111=5, 11110=6, 11100=7, 11000=8, 10000=9; the other 22 codes SHALL be illegal.
REQ-017 All outputs SHALL be registered, reflecting the sample taken on the previous enabled edge, so latency from count_in to outputs is 1 cycle.
REQ-018 On an enabled legal sample, in any state, phase_idx SHALL be loaded and phase_onehot SHALL be set to exactly one bit.
REQ-019 On an enabled illegal sample, phase_onehot SHALL be 0, phase_idx SHALL hold, and illegal_code SHALL pulse for 1 cycle.
REQ-020 A successor SHALL be legal when the new index equals the previous index (hold) or (previous+1) mod 10.
REQ-021 SYNC SHALL move to TRACK after two consecutive enabled legal samples forming a strict advance (k then k+1 mod 10); holds and illegal codes restart the qualification.
REQ-022 TRACK SHALL move to FAULT on an illegal code (illegal_code pulse) or on an illegal successor (seq_error pulse); err_sticky SHALL be set in the same update.
REQ-023 FAULT SHALL move to SYNC on clr_err=1, clearing err_sticky; samples continue to update the phase outputs, but no error pulses SHALL be raised in FAULT.
REQ-024 When clr_err and a new error occur in the same cycle in TRACK, the error SHALL win: the FSM enters FAULT and err_sticky is 1.
REQ-025 clr_err in SYNC or TRACK with no error SHALL have no effect.
REQ-026 In TRACK, an accepted transition 9 -> 0 SHALL increment rev_count modulo 2^REV_W and pulse rev_tick for 1 cycle; no other state SHALL change rev_count.
REQ-027 rev_count SHALL wrap from 2^REV_W-1 to 0 without raising any flag.
REQ-028 seq_error and illegal_code SHALL never both be high in the same cycle.

Reset
REQ-029 With reset=1 at a rising edge: state=SYNC, phase_onehot=0, phase_idx=0, valid=0, illegal_code=0, seq_error=0, err_sticky=0, rev_count=0, rev_tick=0.
REQ-030 Reset SHALL take priority over sample_en and clr_err; reset mid-revolution SHALL discard the partial revolution.

Verification
REQ-031 Reset, then drive the full legal sequence 00000..10000, 00000 with sample_en=1 -> TRACK after the 2nd sample; phase_idx follows 0..9,0; rev_tick is 1 once; rev_count=1.
REQ-032 In TRACK, drive 00111 then 10101 -> illegal_code pulses, phase_onehot=0, phase_idx stays 3, state=FAULT, err_sticky=1.
REQ-033 In TRACK at index 2, drive 01111 (index 4) -> seq_error pulses, state=FAULT; then clr_err=1 -> state=SYNC, err_sticky=0.
REQ-034 Set REV_W=8 and drive 256 revolutions -> rev_count=0 and rev_tick pulses 256 times.
REQ-035 Hold count_in at 11100 for 5 enabled cycles in TRACK, then deassert sample_en while changing count_in to 00000 -> no error, phase_idx=7, outputs unchanged.
REQ-036 Apply an illegal successor and clr_err in the same cycle in TRACK -> state=FAULT, err_sticky=1; assert reset mid-revolution -> all REQ-029 values on the next edge.
